wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Collects results from the execution units into the single register-file write port.
- Each unit hands off {rn, data} through a valid/ready handshake into a one-entry holding slot. A round-robin arbiter then retires one slot per cycle.
- Every retirement drives the RF write and reports the written register on free_rn, so the pending-register table clears its busy bit.
- Sits between the execution units and the register file / pending-register table.

Parameters:
- N_UNITS, 3, number of execution-unit result sources (0=ALU, 1=MEM, 2=MULDIV).
- XLEN, 64, result data width.
- RN_W, 6, register-number width (64 architectural regs, r0 hardwired zero).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  N_UNITS  unit i offers a result
- in_ready  out  N_UNITS  unit i result accepted this cycle when valid&ready
- in_rn  in  N_UNITS*RN_W  destination register, unit i at [i*RN_W +: RN_W]
- in_data  in  N_UNITS*XLEN  result data, unit i at [i*XLEN +: XLEN]
- rf_we  out  1  register-file write enable
- rf_waddr  out  RN_W  register-file write address
- rf_wdata  out  XLEN  register-file write data
- free_rn  out  RN_W  register released to the pending table; 0 when idle
- wb_grant  out  N_UNITS  one-hot unit retired this cycle (debug/perf)

Behaviour:
- Per-unit slot state: full[i], rn[i], data[i]. All slot registers are reset asynchronously.
- Reset values:
  - full=0, rr_ptr=0.
  - All outputs read 0, except in_ready, which reads all-ones.
- Accept rule:
  - in_ready[i] = ~full[i] | wb_grant[i]. A slot can drain and refill in the same cycle, giving 1 result/cycle/unit throughput.
  - On valid&ready at a clk edge, the slot captures rn/data and full[i] is set.
  - If the slot is granted without a new accept, full[i] is cleared.
- Arbitration (combinational from slot state):
  - The first full slot at or after rr_ptr, searching circularly with wrap from N_UNITS-1 to 0, is granted.
  - On any grant, rr_ptr <= granted index + 1 (mod N_UNITS). With no grant, rr_ptr holds.
  - Fairness: a full slot is granted within N_UNITS cycles.
- Output, driven combinationally from the granted slot:
  - rf_waddr=rn[g], rf_wdata=data[g], free_rn=rn[g].
  - rf_we = |wb_grant & (rn[g]!=0).
- Idle: rf_we=0, rf_waddr=0, rf_wdata=0, free_rn=0. The pending table clears free_rn every cycle, and clearing r0 is harmless.
- Latency: a result accepted at edge T is written and freed in the cycle following T at the earliest; worst case is N_UNITS cycles later.
- Bypass: no bypass from in_* to the output. A result never retires in its accept cycle.
- r0 destination: the result is accepted and retired normally through a grant, rf_we=0, free_rn=0.
- Same rn pending in two slots: both retire separately in arbitration order, with no merging. The later write wins in the RF.
- Reset mid-operation: all held results are dropped with no writes issued. in_ready returns to all-ones immediately.
- Invalid input: in_rn/in_data are ignored when in_valid=0. X on unused inputs must not propagate to outputs.

Decomposition:
- Shared package raisin64_pkg:
  - XLEN and RN_W constants.
  - Unit index constants UNIT_ALU=0, UNIT_MEM=1, UNIT_MULDIV=2.
  - N_UNITS default.
- Sub-module rr_arbiter:
  - Parameter N, inputs req[N], pointer register, output one-hot gnt[N].
  - Clocked, with asynchronous rst_n.
  - Reused by the issue stage.
- Holding slots and output muxing stay in wb_arbiter.

Test Plan:
- Reset then idle:
  - rf_we=0, free_rn=0, in_ready=3'b111, wb_grant=0 for 10 cycles.
- Single result: ALU valid 1 cycle with rn=5, data=0xDEAD_BEEF.
  - Next cycle: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, free_rn=5, wb_grant=3'b001.
  - Following cycle idle.
- Three-way collision: all units valid same cycle, rn=1/2/3, valid then held low.
  - Retire order unit0, unit1, unit2 on 3 consecutive cycles with free_rn=1,2,3.
  - rr_ptr returns to 0.
- Back-to-back from one unit: MEM valid continuously for 8 cycles, rn=10..17, others idle.
  - in_ready[1] stays 1.
  - One write per cycle, rn 10..17 in order, no bubbles.
- Fairness under load: ALU and MULDIV valid every cycle.
  - Grants alternate 001/100.
  - Neither unit's in_ready is low for more than 1 consecutive cycle.
- r0 and reset edge cases:
  - ALU result rn=0 retires with wb_grant=001, rf_we=0, free_rn=0.
  - rst_n asserted with 3 slots full: no writes after deassert, in_ready=111.

Source files
------------

// File: rtl/raisin64_pkg.sv
// raisin64_pkg
//   Constants shared by the write-back arbiter and its neighbours:
//   datapath width, register-number width, and the execution-unit
//   indices that set the order of the arbiter request vector.
//   No ports (package).

package raisin64_pkg;

  localparam int XLEN            = 64;
  localparam int RN_W            = 6;
  localparam int N_UNITS_DEFAULT = 3;

  // Execution-unit positions in the in_valid / wb_grant vectors
  localparam int UNIT_ALU    = 0;
  localparam int UNIT_MEM    = 1;
  localparam int UNIT_MULDIV = 2;

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
//   Groups the execution-unit result handshake and the register-file /
//   pending-table write-back signals.
//   Unit side   : in_valid, in_rn, in_data  ->  in_ready
//   Result side : rf_we, rf_waddr, rf_wdata, free_rn, wb_grant
//   Modports:
//     slave  - the arbiter (consumes unit results, drives the RF write)
//     master - the environment (units offering results, RF observing)

interface wb_arbiter_if #(
  parameter int N_UNITS = raisin64_pkg::N_UNITS_DEFAULT,
  parameter int XLEN    = raisin64_pkg::XLEN,
  parameter int RN_W    = raisin64_pkg::RN_W
);
  import raisin64_pkg::*;

  logic [N_UNITS-1:0]      in_valid;
  logic [N_UNITS-1:0]      in_ready;
  logic [N_UNITS*RN_W-1:0] in_rn;
  logic [N_UNITS*XLEN-1:0] in_data;

  logic                    rf_we;
  logic [RN_W-1:0]         rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic [RN_W-1:0]         free_rn;
  logic [N_UNITS-1:0]      wb_grant;

  modport slave (
    input  in_valid, in_rn, in_data,
    output in_ready, rf_we, rf_waddr, rf_wdata, free_rn, wb_grant
  );

  modport master (
    output in_valid, in_rn, in_data,
    input  in_ready, rf_we, rf_waddr, rf_wdata, free_rn, wb_grant
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a registered priority pointer. The grant is
//   combinational from req_i and the pointer: the first requester at or
//   after the pointer (circular) wins. After a grant the pointer moves to
//   one past the winner; with no request it holds.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (pointer -> 0)
//     req_i [N]   request vector
//     gnt_o [N]   one-hot grant (all zero when nothing requests)

module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  import raisin64_pkg::*;

  localparam int              PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W:0]  N_EXT = (PTR_W+1)'(N);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gntIdx;
  logic             anyGnt;
  logic [PTR_W:0]   cand;
  logic [PTR_W:0]   nextPtr;

  // Circular search starting at the pointer; the candidate index is kept
  // one bit wider so the wrap from N-1 back to 0 works for any N.
  always_comb begin
    gnt_o  = '0;
    gntIdx = '0;
    anyGnt = 1'b0;
    cand   = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!anyGnt && req_i[cand[PTR_W-1:0]]) begin
        anyGnt                = 1'b1;
        gntIdx                = cand[PTR_W-1:0];
        gnt_o[cand[PTR_W-1:0]] = 1'b1;
      end
    end
  end

  // Pointer moves to one past the winner so the winner has lowest
  // priority next time; no grant leaves it where it was.
  always_comb begin
    nextPtr = {1'b0, gntIdx} + (PTR_W+1)'(1);
    if (nextPtr >= N_EXT) nextPtr = '0;
    ptr_d = anyGnt ? nextPtr[PTR_W-1:0] : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Funnels execution-unit results into the single register-file write
//   port. Each unit owns a one-entry holding slot filled through a
//   valid/ready handshake; a round-robin arbiter retires one full slot per
//   cycle, writing the RF and releasing the register on free_rn.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (drops held results)
//     bus         wb_arbiter_if.slave: unit handshake in, RF write out

module wb_arbiter #(
  parameter int N_UNITS = raisin64_pkg::N_UNITS_DEFAULT,
  parameter int XLEN    = raisin64_pkg::XLEN,
  parameter int RN_W    = raisin64_pkg::RN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  import raisin64_pkg::*;

  logic [N_UNITS-1:0]           full_q, full_d;
  logic [N_UNITS-1:0][RN_W-1:0] rn_q, rn_d;
  logic [N_UNITS-1:0][XLEN-1:0] data_q, data_d;

  logic [N_UNITS-1:0] gnt;
  logic [N_UNITS-1:0] readyInt;
  logic [N_UNITS-1:0] accept;
  logic [RN_W-1:0]    selRn;
  logic [XLEN-1:0]    selData;

  rr_arbiter #(.N(N_UNITS)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (full_q),
    .gnt_o (gnt)
  );

  // A slot being retired this cycle can take a new result at the same
  // edge, so a unit streaming results sees no bubble.
  always_comb begin
    readyInt = ~full_q | gnt;
    accept   = bus.in_valid & readyInt;
  end

  // Slot update: a new accept always wins over the drain, so a granted
  // slot that refills stays full. rn/data are only loaded on accept, so
  // junk on in_rn/in_data with valid low never enters a slot.
  always_comb begin
    full_d = full_q;
    rn_d   = rn_q;
    data_d = data_q;
    for (int i = 0; i < N_UNITS; i++) begin
      if (accept[i]) begin
        full_d[i] = 1'b1;
        rn_d[i]   = bus.in_rn[i*RN_W +: RN_W];
        data_d[i] = bus.in_data[i*XLEN +: XLEN];
      end else if (gnt[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      rn_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rn_q   <= rn_d;
      data_q <= data_d;
    end
  end

  // AND-OR mux on the one-hot grant: every output collapses to zero when
  // idle, and only slot contents (never live inputs) reach the RF port.
  always_comb begin
    selRn   = '0;
    selData = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      selRn   = selRn   | (rn_q[i]   & {RN_W{gnt[i]}});
      selData = selData | (data_q[i] & {XLEN{gnt[i]}});
    end
  end

  // r0 still consumes a grant but never writes; free_rn of 0 is harmless
  // to the pending table.
  always_comb begin
    bus.in_ready = readyInt;
    bus.wb_grant = gnt;
    bus.rf_we    = (|gnt) && (selRn != '0);
    bus.rf_waddr = selRn;
    bus.rf_wdata = selData;
    bus.free_rn  = selRn;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter: a table of per-cycle vectors with
//   hand-derived expected outputs, plus scoreboarded streaming scenarios
//   and a mid-operation reset sequence.

module tb_wb_arbiter;
  import raisin64_pkg::*;

  logic clk;
  logic rst_n;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct packed {
    logic [2:0]       valid;
    logic [2:0][5:0]  rn;
    logic [2:0][63:0] data;
    logic [2:0]       expGrant;
    logic             expWe;
    logic [5:0]       expWaddr;
    logic [63:0]      expWdata;
    logic [5:0]       expFree;
    logic [2:0]       expReady;
  } vec_t;

  typedef struct packed {
    logic [5:0]  rn;
    logic [63:0] data;
  } res_t;

  vec_t vecs [13];
  res_t q0 [$];
  res_t q1 [$];
  res_t q2 [$];

  int remaining [3];
  int seqNum    [3];
  int rnBase    [3];
  int lowRun    [3];
  int maxLow    [3];

  // Single comparison point: every check steps totalCnt, passes step passCnt
  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passCnt++;
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [5:0] r0, r1, r2,
                              input logic [63:0] d0, d1, d2, input logic [2:0] g,
                              input logic we, input logic [5:0] wa, input logic [63:0] wd,
                              input logic [5:0] fr, input logic [2:0] rdy);
    vec_t t;
    t.valid = v;
    t.rn[0] = r0; t.rn[1] = r1; t.rn[2] = r2;
    t.data[0] = d0; t.data[1] = d1; t.data[2] = d2;
    t.expGrant = g; t.expWe = we; t.expWaddr = wa;
    t.expWdata = wd; t.expFree = fr; t.expReady = rdy;
    return t;
  endfunction

  task automatic clearInputs();
    bus.in_valid = '0;
    bus.in_rn    = '0;
    bus.in_data  = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Unused unit lanes get X so any leak into the outputs shows up
  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid[i] = v.valid[i];
      bus.in_rn[i*6 +: 6]    = v.valid[i] ? v.rn[i]   : 6'bx;
      bus.in_data[i*64 +: 64] = v.valid[i] ? v.data[i] : 64'bx;
    end
  endtask

  task automatic checkOutput(input int k, input vec_t v);
    checkVal($sformatf("row%0d grant", k), 64'(bus.wb_grant), 64'(v.expGrant));
    checkVal($sformatf("row%0d rf_we", k), 64'(bus.rf_we),    64'(v.expWe));
    checkVal($sformatf("row%0d waddr", k), 64'(bus.rf_waddr), 64'(v.expWaddr));
    checkVal($sformatf("row%0d wdata", k), bus.rf_wdata,      v.expWdata);
    checkVal($sformatf("row%0d free", k),  64'(bus.free_rn),  64'(v.expFree));
    checkVal($sformatf("row%0d ready", k), 64'(bus.in_ready), 64'(v.expReady));
  endtask

  // Producers hold a result until in_ready; on handshake the expected
  // retirement is pushed to that unit's queue.
  task automatic produceCycle();
    res_t r;
    for (int i = 0; i < 3; i++) begin
      if (remaining[i] > 0) begin
        r.rn   = 6'(rnBase[i] + seqNum[i]);
        r.data = 64'hA000_0000_0000_0000 | (64'(i) << 8) | 64'(seqNum[i]);
        bus.in_valid[i] = 1'b1;
        bus.in_rn[i*6 +: 6]     = r.rn;
        bus.in_data[i*64 +: 64] = r.data;
        if (bus.in_ready[i]) begin
          case (i)
            0: q0.push_back(r);
            1: q1.push_back(r);
            default: q2.push_back(r);
          endcase
          seqNum[i]++;
          remaining[i]--;
        end
      end else begin
        bus.in_valid[i] = 1'b0;
        bus.in_rn[i*6 +: 6]     = 6'bx;
        bus.in_data[i*64 +: 64] = 64'bx;
      end
    end
  endtask

  // On every retirement, pop the granted unit's oldest expected result
  task automatic checkRetire();
    res_t r;
    logic ok;
    if (bus.wb_grant != 3'b000) begin
      ok = 1'b1;
      case (bus.wb_grant)
        3'b001: if (q0.size() > 0) r = q0.pop_front(); else ok = 1'b0;
        3'b010: if (q1.size() > 0) r = q1.pop_front(); else ok = 1'b0;
        3'b100: if (q2.size() > 0) r = q2.pop_front(); else ok = 1'b0;
        default: ok = 1'b0;
      endcase
      checkVal("retire expected", 64'(ok), 64'd1);
      if (ok) begin
        checkVal("sb waddr", 64'(bus.rf_waddr), 64'(r.rn));
        checkVal("sb wdata", bus.rf_wdata, r.data);
        checkVal("sb free",  64'(bus.free_rn), 64'(r.rn));
        checkVal("sb we",    64'(bus.rf_we), 64'(r.rn != 6'd0));
      end
    end
  endtask

  task automatic setProducers(input int n0, n1, n2, input int b0, b1, b2);
    remaining[0] = n0; remaining[1] = n1; remaining[2] = n2;
    rnBase[0] = b0; rnBase[1] = b1; rnBase[2] = b2;
    for (int i = 0; i < 3; i++) begin
      seqNum[i] = 0; lowRun[i] = 0; maxLow[i] = 0;
    end
  endtask

  initial begin
    int drainCycles;
    rst_n = 1'b0;
    clearInputs();

    vecs[0]  = mk(3'b111, 1, 2, 3, 64'hA1, 64'hA2, 64'hA3, 3'b000, 0, 0, 0, 0, 3'b111);
    vecs[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 1, 1, 64'hA1, 1, 3'b001);
    vecs[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 1, 2, 64'hA2, 2, 3'b011);
    vecs[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 1, 3, 64'hA3, 3, 3'b111);
    vecs[4]  = mk(3'b011, 5, 9, 0, 64'hDEAD_BEEF, 64'h99, 0, 3'b000, 0, 0, 0, 0, 3'b111);
    vecs[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 1, 5, 64'hDEAD_BEEF, 5, 3'b101);
    vecs[6]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 1, 9, 64'h99, 9, 3'b111);
    vecs[7]  = mk(3'b001, 0, 0, 0, 64'h77, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111);
    vecs[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 64'h77, 0, 3'b111);
    vecs[9]  = mk(3'b101, 7, 0, 7, 64'h70, 0, 64'h72, 3'b000, 0, 0, 0, 0, 3'b111);
    vecs[10] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 1, 7, 64'h72, 7, 3'b110);
    vecs[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 1, 7, 64'h70, 7, 3'b111);
    vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111);

    // Reset then idle
    doReset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkVal($sformatf("idle%0d we", c),    64'(bus.rf_we), 64'd0);
      checkVal($sformatf("idle%0d free", c),  64'(bus.free_rn), 64'd0);
      checkVal($sformatf("idle%0d ready", c), 64'(bus.in_ready), 64'b111);
      checkVal($sformatf("idle%0d grant", c), 64'(bus.wb_grant), 64'd0);
    end

    // Table: collision order, pointer wrap, single result, r0, duplicate rn
    doReset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      checkOutput(k, vecs[k]);
      applyStimulus(vecs[k]);
    end

    // MEM streaming back-to-back: one write per cycle, no bubbles
    doReset();
    setProducers(0, 8, 0, 0, 10, 0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      checkRetire();
      if (c <= 8) checkVal($sformatf("mem ready c%0d", c), 64'(bus.in_ready[1]), 64'd1);
      if (c >= 1 && c <= 8)
        checkVal($sformatf("mem grant c%0d", c), 64'(bus.wb_grant), 64'b010);
      else
        checkVal($sformatf("mem grant c%0d", c), 64'(bus.wb_grant), 64'b000);
      produceCycle();
    end

    // ALU + MULDIV under continuous load: grants alternate
    doReset();
    setProducers(6, 0, 6, 20, 0, 40);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checkRetire();
      if (c >= 1 && c <= 12)
        checkVal($sformatf("fair grant c%0d", c), 64'(bus.wb_grant),
                 (c % 2 == 1) ? 64'b001 : 64'b100);
      else
        checkVal($sformatf("fair grant c%0d", c), 64'(bus.wb_grant), 64'b000);
      for (int i = 0; i < 3; i++) begin
        if (remaining[i] > 0 && !bus.in_ready[i]) lowRun[i]++;
        else lowRun[i] = 0;
        if (lowRun[i] > maxLow[i]) maxLow[i] = lowRun[i];
      end
      produceCycle();
    end
    checkVal("fair alu max low run", 64'(maxLow[0] <= 1), 64'd1);
    checkVal("fair muldiv max low run", 64'(maxLow[2] <= 1), 64'd1);

    // Every pushed result must have retired
    drainCycles = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && drainCycles < 20) begin
      @(negedge clk);
      checkRetire();
      drainCycles++;
    end
    checkVal("scoreboard drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    // Reset with all three slots full: results dropped, ready back at once
    doReset();
    @(negedge clk);
    bus.in_valid = 3'b111;
    bus.in_rn    = {6'd32, 6'd31, 6'd30};
    bus.in_data  = {64'h3, 64'h2, 64'h1};
    @(negedge clk);
    clearInputs();
    checkVal("full before rst grant", 64'(bus.wb_grant), 64'b001);
    checkVal("full before rst ready", 64'(bus.in_ready), 64'b001);
    rst_n = 1'b0;
    #1;
    checkVal("in rst ready", 64'(bus.in_ready), 64'b111);
    checkVal("in rst we",    64'(bus.rf_we), 64'd0);
    checkVal("in rst grant", 64'(bus.wb_grant), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkVal($sformatf("post rst%0d we", c),    64'(bus.rf_we), 64'd0);
      checkVal($sformatf("post rst%0d grant", c), 64'(bus.wb_grant), 64'd0);
      checkVal($sformatf("post rst%0d ready", c), 64'(bus.in_ready), 64'b111);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
